// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one internal bus among 8 requesters.
// Emits a decoder-ready owner index/enable plus a one-hot grant with a hold limit.
module rr_bus_arbiter #(
   parameter int unsigned HOLD_MAX = 4,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic [7:0] grant,
   output logic       timeout,
   output logic [2:0] ptr
);

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic               grant_valid_q, grant_valid_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               timeout_q, timeout_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   cand;
   logic               hold_hit;
   logic               owner_req;

   // First requester at or after ptr, wrapping mod 8.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = ptr_q + IDX_W'(i);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign hold_hit  = (hold_cnt_q == CNT_W'(HOLD_MAX));
   assign owner_req = req[grant_idx_q];

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      hold_cnt_d    = hold_cnt_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      grant_d       = grant_q;
      timeout_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d       = ST_GRANT;
               grant_idx_d   = win_idx;
               grant_valid_d = 1'b1;
               grant_d       = NUM_REQ'(1) << win_idx;
               hold_cnt_d    = CNT_W'(1);
            end else begin
               grant_idx_d   = '0;
               grant_valid_d = 1'b0;
               grant_d       = '0;
               hold_cnt_d    = '0;
            end
         end
         ST_GRANT: begin
            // done outranks owner drop, which outranks hold expiry.
            if (done || !owner_req || hold_hit) begin
               state_d       = ST_TURN;
               ptr_d         = grant_idx_q + IDX_W'(1);
               grant_valid_d = 1'b0;
               grant_d       = '0;
               hold_cnt_d    = '0;
               timeout_d     = !done && owner_req && hold_hit;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         ST_TURN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d       = ST_IDLE;
            grant_valid_d = 1'b0;
            grant_d       = '0;
            hold_cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         hold_cnt_q    <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         grant_q       <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         hold_cnt_q    <= hold_cnt_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
         grant_q       <= grant_d;
         timeout_q     <= timeout_d;
      end
   end

   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign grant       = grant_q;
   assign timeout     = timeout_q;
   assign ptr         = ptr_q;

endmodule
